// File: rtl/adder_reg_pkg.sv
// Shared constants for the registered block carry-lookahead adder.
// Default widths plus the block-count helper used by the top level.
package adder_reg_pkg;

    localparam int unsigned ADDER_N_DEFAULT     = 21;
    localparam int unsigned ADDER_BLOCK_DEFAULT = 4;

    function automatic int unsigned num_blocks(input int unsigned n, input int unsigned blk);
        return (n + blk - 1) / blk;
    endfunction

endpackage

// File: rtl/adder_reg_cla_block.sv
// One carry-lookahead block: lookahead internal carries from cin, plus
// block generate/propagate; W may be narrower for the partial last block.
module cla_block #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         blk_g,
    output logic         blk_p,
    output logic         cout
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;
    logic         gen_acc;
    logic         prop_acc;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is a flat sum of products over g/p below it, not a ripple.
    always_comb begin
        c        = '0;
        gen_acc  = 1'b0;
        prop_acc = 1'b0;
        c[0]     = cin;
        for (int unsigned i = 0; i < W; i++) begin
            gen_acc  = g[i];
            prop_acc = p[i];
            for (int unsigned k = 0; k < i; k++) begin
                gen_acc  = gen_acc | (prop_acc & g[i-1-k]);
                prop_acc = prop_acc & p[i-1-k];
            end
            c[i+1] = gen_acc | (prop_acc & cin);
        end
    end

    always_comb begin
        blk_g    = 1'b0;
        blk_p    = 1'b1;
        for (int unsigned i = 0; i < W; i++) begin
            blk_g = g[i] | (p[i] & blk_g);
            blk_p = blk_p & p[i];
        end
    end

    assign s    = p ^ c[W-1:0];
    assign cout = c[W];

endmodule

// File: rtl/adder_reg.sv
// N-bit unsigned modular adder, block carry-lookahead with rippled block
// carries, {cout, sum} registered with one cycle of latency.
module adder_reg
    import adder_reg_pkg::*;
#(
    parameter int unsigned N     = ADDER_N_DEFAULT,
    parameter int unsigned BLOCK = ADDER_BLOCK_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] input1,
    input  logic [N-1:0] input2,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int unsigned NB = num_blocks(N, BLOCK);

    logic [NB:0]   blk_c;
    logic [NB-1:0] blk_g;
    logic [NB-1:0] blk_p;
    logic [N-1:0]  sum_c;
    logic [N-1:0]  sum_d;
    logic [N-1:0]  sum_q;
    logic          cout_d;
    logic          cout_q;
    logic          unused_blk_gp;

    assign blk_c[0] = 1'b0;

    for (genvar k = 0; k < NB; k++) begin : g_blk
        localparam int unsigned LO = k * BLOCK;
        localparam int unsigned W  = (LO + BLOCK > N) ? (N - LO) : BLOCK;

        cla_block #(
            .W(W)
        ) u_cla (
            .a    (input1[LO +: W]),
            .b    (input2[LO +: W]),
            .cin  (blk_c[k]),
            .s    (sum_c[LO +: W]),
            .blk_g(blk_g[k]),
            .blk_p(blk_p[k]),
            .cout (blk_c[k+1])
        );
    end

    // Block G/P are left for a second-level lookahead; carries ripple via cout.
    assign unused_blk_gp = ^{blk_g, blk_p};

    always_comb begin
        sum_d  = sum_c;
        cout_d = blk_c[NB];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_adder_reg.sv
// Scoreboard bench for adder_reg (N=21, BLOCK=4): expected {cout,sum} is
// queued when operands are driven and compared one clock later.
module tb_adder_reg;

    localparam int unsigned N = 21;

    logic         clk;
    logic         rst;
    logic [N-1:0] input1;
    logic [N-1:0] input2;
    logic [N-1:0] sum;
    logic         cout;

    logic [N:0]   exp_q[$];
    int unsigned  n_total;
    int unsigned  n_bad;

    adder_reg #(
        .N    (21),
        .BLOCK(4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .input1(input1),
        .input2(input2),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [N:0] obs, input logic [N:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got cout=%0b sum=0x%06h, want cout=%0b sum=0x%06h",
                     tag, obs[N], obs[N-1:0], exp[N], exp[N-1:0]);
        end
    endtask

    // Drive one operand pair, queue the model result, check one cycle later.
    task automatic step(input string tag, input logic r, input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N:0] e;
        rst    = r;
        input1 = a;
        input2 = b;
        e      = r ? '0 : ({1'b0, a} + {1'b0, b});
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            check_val(tag, {cout, sum}, exp_q.pop_front());
        end
    endtask

    logic [41:0] pat;
    logic [41:0] one42;
    int unsigned idx;

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst     = 1'b1;
        input1  = '0;
        input2  = '0;
        one42   = 42'd1;

        // Reset with all-ones operands, then release holding them.
        step("rst0", 1'b1, 21'h1FFFFF, 21'h1FFFFF);
        step("rst1", 1'b1, 21'h1FFFFF, 21'h1FFFFF);
        step("rst_release", 1'b0, 21'h1FFFFF, 21'h1FFFFF);
        check_val("rst_release_const", {cout, sum}, {1'b1, 21'h1FFFFE});

        step("basic0", 1'b0, 21'h1FF800, 21'h1FFFFF);
        check_val("basic0_const", {cout, sum}, {1'b1, 21'h1FF7FF});
        step("basic_zero", 1'b0, 21'h000000, 21'h000000);
        check_val("basic_zero_const", {cout, sum}, {1'b0, 21'h000000});

        step("prop_all", 1'b0, 21'h000001, 21'h1FFFFF);
        check_val("prop_all_const", {cout, sum}, {1'b1, 21'h000000});
        step("prop_top", 1'b0, 21'h0FFFFF, 21'h000001);
        check_val("prop_top_const", {cout, sum}, {1'b0, 21'h100000});

        step("blk_bound0", 1'b0, 21'h00000F, 21'h000001);
        check_val("blk_bound0_const", {cout, sum}, {1'b0, 21'h000010});
        step("blk_bound1", 1'b0, 21'h0FFFF0, 21'h000010);
        check_val("blk_bound1_const", {cout, sum}, {1'b0, 21'h100000});

        // Held operands: output must stay put across cycles.
        for (int unsigned i = 0; i < 3; i++)
            step("hold", 1'b0, 21'h155555, 21'h0AAAAB);
        check_val("hold_const", {cout, sum}, {1'b1, 21'h000000});

        // Streaming walking ones/zeros, one reset slot mid-burst.
        idx = 0;
        for (int unsigned burst = 0; burst < 10; burst++) begin
            for (int unsigned i = 0; i < 20; i++) begin
                pat = one42 << (idx % 42);
                if ((idx % 84) >= 42)
                    pat = ~pat;
                idx++;
                step("stream", (burst == 5 && i == 10), pat[20:0], pat[41:21]);
            end
            for (int unsigned i = 0; i < 7; i++)
                step("idle", 1'b0, '0, '0);
        end

        // Lone reset slot followed by immediate resume.
        step("mid_pre", 1'b0, 21'h1FFFFF, 21'h000002);
        step("mid_rst", 1'b1, 21'h1FFFFF, 21'h000002);
        check_val("mid_rst_const", {cout, sum}, '0);
        step("mid_post", 1'b0, 21'h1FFFFF, 21'h000002);
        check_val("mid_post_const", {cout, sum}, {1'b1, 21'h000001});

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
